// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix column scanner.
// Holds the source-select mode encodings, the scan FSM state enum and a
// width helper used to size column and counter registers.
package matrix_pkg;

   // Source-select encodings on the mode input
   typedef enum logic [1:0] {
      MODE_OFF = 2'b00,
      MODE_A   = 2'b01,
      MODE_B   = 2'b10,
      MODE_ALT = 2'b11
   } mode_e;

   // Scan FSM: one START cycle per frame, then BLANK/DRIVE per column
   typedef enum logic [1:0] {
      START = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   // $clog2 that never returns 0, so a one-value register still has a bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_dwell_timer.sv
// Loadable down-counter that paces the BLANK and DRIVE phases.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  synchronous active-low reset
//   load     in  1  load load_val this edge (takes priority over counting)
//   load_val in  W  value loaded; the phase lasts load_val+1 cycles
//   done     out 1  count has reached zero (terminal count)
module matrix_dwell_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count_q, count_d;

   // Next count: a load wins; otherwise step down and park at zero so the
   // counter can never wrap past its terminal value.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column-multiplexed LED-matrix scanner.
// Each frame starts with one START cycle that snapshots the selected source
// into a shadow frame, then every column gets BLANK_CYCLES dark cycles
// followed by DWELL_CYCLES driven cycles. All outputs are registered.
// Ports:
//   clk         in   1               rising-edge clock
//   rst_n       in   1               synchronous active-low reset
//   en          in   1               scan enable; low restarts the scan dark
//   mode        in   2               00 off, 01 A, 10 B, 11 alternate A/B
//   frame_a     in   N_COLS*N_ROWS   source A, column c at [c*N_ROWS +: N_ROWS]
//   frame_b     in   N_COLS*N_ROWS   source B, same packing
//   columns     out  N_COLS          one-hot column select (polarity applied)
//   lines       out  N_ROWS          row pattern of driven column (polarity applied)
//   col_idx     out  CW              column currently being scanned
//   frame_start out  1               pulse on the first cycle of each frame
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int N_COLS         = 5,
   parameter int N_ROWS         = 7,
   parameter int DWELL_CYCLES   = 1,
   parameter int BLANK_CYCLES   = 0,
   parameter int BLINK_FRAMES   = 1,
   parameter bit COL_ACTIVE_LOW = 1'b0,
   parameter bit ROW_ACTIVE_LOW = 1'b0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic [1:0]                      mode,
   input  logic [N_COLS*N_ROWS-1:0]        frame_a,
   input  logic [N_COLS*N_ROWS-1:0]        frame_b,
   output logic [N_COLS-1:0]               columns,
   output logic [N_ROWS-1:0]               lines,
   output logic [clog2_min1(N_COLS)-1:0]   col_idx,
   output logic                            frame_start
);

   localparam int CW     = clog2_min1(N_COLS);
   localparam int MAXT   = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int TW     = clog2_min1(MAXT + 1);
   localparam int AW     = clog2_min1(BLINK_FRAMES);
   localparam int FW     = N_COLS * N_ROWS;

   localparam logic [TW-1:0]     DWELL_LOAD = TW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0]     BLANK_LOAD = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [AW-1:0]     ALT_LAST   = AW'(BLINK_FRAMES - 1);
   localparam logic [CW-1:0]     COL_LAST   = CW'(N_COLS - 1);
   localparam logic [N_COLS-1:0] COL_MASK   = {N_COLS{COL_ACTIVE_LOW}};
   localparam logic [N_ROWS-1:0] ROW_MASK   = {N_ROWS{ROW_ACTIVE_LOW}};

   state_e              state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [FW-1:0]       shadow_q, shadow_d;
   mode_e               mode_q, mode_d;
   logic [AW-1:0]       alt_cnt_q, alt_cnt_d;
   logic                alt_b_q, alt_b_d;
   logic [N_COLS-1:0]   columns_q, columns_d;
   logic [N_ROWS-1:0]   lines_q, lines_d;
   logic [CW-1:0]       col_idx_q, col_idx_d;
   logic                frame_start_q, frame_start_d;
   logic [N_COLS-1:0]   columns_raw;
   logic [N_ROWS-1:0]   lines_raw;
   logic                timer_load;
   logic [TW-1:0]       timer_val;
   logic                timer_done;

   matrix_dwell_timer #(
      .W(TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // Next-state and output logic. state_q names the phase executed at the
   // coming edge; the outputs registered at that edge show that phase.
   // After a column's last DRIVE cycle the next column's BLANK (or DRIVE when
   // blanking is disabled) is entered with a fresh timer load, and the last
   // column wraps straight back into START with no gap cycle.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      shadow_d      = shadow_q;
      mode_d        = mode_q;
      alt_cnt_d     = alt_cnt_q;
      alt_b_d       = alt_b_q;
      col_idx_d     = col_q;
      frame_start_d = 1'b0;
      columns_raw   = '0;
      lines_raw     = '0;
      timer_load    = 1'b0;
      timer_val     = DWELL_LOAD;

      if (!en) begin
         state_d    = START;
         col_d      = '0;
         col_idx_d  = '0;
         timer_load = 1'b1;
      end else begin
         unique case (state_q)
            START: begin
               frame_start_d = 1'b1;
               col_idx_d     = '0;
               mode_d        = mode_e'(mode);
               // Snapshot the frame now so later source changes cannot tear it
               unique case (mode_e'(mode))
                  MODE_A:   shadow_d = frame_a;
                  MODE_B:   shadow_d = frame_b;
                  MODE_ALT: shadow_d = alt_b_q ? frame_b : frame_a;
                  default:  shadow_d = '0;
               endcase
               // Alternation advances once per ALT frame and restarts on A
               // as soon as a non-ALT frame is latched
               if (mode_e'(mode) == MODE_ALT) begin
                  if (alt_cnt_q == ALT_LAST) begin
                     alt_cnt_d = '0;
                     alt_b_d   = ~alt_b_q;
                  end else begin
                     alt_cnt_d = alt_cnt_q + AW'(1);
                  end
               end else begin
                  alt_cnt_d = '0;
                  alt_b_d   = 1'b0;
               end
               timer_load = 1'b1;
               if (BLANK_CYCLES > 0) begin
                  state_d   = BLANK;
                  timer_val = BLANK_LOAD;
               end else begin
                  state_d   = DRIVE;
               end
            end
            BLANK: begin
               if (timer_done) begin
                  state_d    = DRIVE;
                  timer_load = 1'b1;
               end
            end
            DRIVE: begin
               if (mode_q != MODE_OFF) begin
                  columns_raw = N_COLS'(1) << col_q;
                  lines_raw   = shadow_q[int'(col_q)*N_ROWS +: N_ROWS];
               end
               if (timer_done) begin
                  timer_load = 1'b1;
                  if (col_q == COL_LAST) begin
                     col_d   = '0;
                     state_d = START;
                  end else begin
                     col_d = col_q + CW'(1);
                     if (BLANK_CYCLES > 0) begin
                        state_d   = BLANK;
                        timer_val = BLANK_LOAD;
                     end else begin
                        state_d   = DRIVE;
                     end
                  end
               end
            end
            default: begin
               state_d = START;
               col_d   = '0;
            end
         endcase
      end

      columns_d = columns_raw ^ COL_MASK;
      lines_d   = lines_raw ^ ROW_MASK;
   end

   // State, shadow frame and output registers; reset leaves everything dark
   // and waiting to run START on the first enabled edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= START;
         col_q         <= '0;
         shadow_q      <= '0;
         mode_q        <= MODE_OFF;
         alt_cnt_q     <= '0;
         alt_b_q       <= 1'b0;
         columns_q     <= COL_MASK;
         lines_q       <= ROW_MASK;
         col_idx_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         shadow_q      <= shadow_d;
         mode_q        <= mode_d;
         alt_cnt_q     <= alt_cnt_d;
         alt_b_q       <= alt_b_d;
         columns_q     <= columns_d;
         lines_q       <= lines_d;
         col_idx_q     <= col_idx_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign columns     = columns_q;
   assign lines       = lines_q;
   assign col_idx     = col_idx_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: two instances (plain 5x7 defaults, and a
// dwell/blank/blink/active-low variant) share one set of inputs and are
// compared every cycle against a frame-position model.
module tb_matrix_scan_ctrl;

   localparam int NC = 5;
   localparam int NR = 7;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [1:0]        mode;
   logic [NC*NR-1:0]  frame_a;
   logic [NC*NR-1:0]  frame_b;

   logic [NC-1:0]     columns0, columns1;
   logic [NR-1:0]     lines0, lines1;
   logic [CW-1:0]     colIdx0, colIdx1;
   logic              frameStart0, frameStart1;

   // Instance parameters, mirrored for the model
   int pDwell  [2] = '{1, 4};
   int pBlank  [2] = '{0, 1};
   int pBlink  [2] = '{1, 2};
   bit pColLow [2] = '{1'b0, 1'b1};
   bit pRowLow [2] = '{1'b0, 1'b1};

   // Model state: position of the next edge inside the frame, latched frame
   int               mPos    [2];
   logic [NC*NR-1:0] mShadow [2];
   logic [1:0]       mMode   [2];
   int               mAltN   [2];

   logic [NC-1:0]    expCols  [2];
   logic [NR-1:0]    expLines [2];
   int               expIdx   [2];
   logic             expFs    [2];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Free-running clock
   always #5 clk = ~clk;

   matrix_scan_ctrl dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mode        (mode),
      .frame_a     (frame_a),
      .frame_b     (frame_b),
      .columns     (columns0),
      .lines       (lines0),
      .col_idx     (colIdx0),
      .frame_start (frameStart0)
   );

   matrix_scan_ctrl #(
      .N_COLS         (NC),
      .N_ROWS         (NR),
      .DWELL_CYCLES   (4),
      .BLANK_CYCLES   (1),
      .BLINK_FRAMES   (2),
      .COL_ACTIVE_LOW (1'b1),
      .ROW_ACTIVE_LOW (1'b1)
   ) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mode        (mode),
      .frame_a     (frame_a),
      .frame_b     (frame_b),
      .columns     (columns1),
      .lines       (lines1),
      .col_idx     (colIdx1),
      .frame_start (frameStart1)
   );

   // Single comparison point; counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycle, actual, expected);
      end
   endtask

   function automatic logic [NC*NR-1:0] randFrame();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[NC*NR-1:0];
   endfunction

   // Model of one edge for instance i: the frame is START followed by NC
   // column slots of (blank+dwell) cycles, the last dwell part being lit
   task automatic modelEdge(input int i);
      int period, k, col, ph;
      logic [NC-1:0] rawCols;
      logic [NR-1:0] rawLines;
      rawCols  = '0;
      rawLines = '0;
      expFs[i] = 1'b0;
      expIdx[i] = 0;
      period = NC * (pBlank[i] + pDwell[i]) + 1;
      if (!rst_n) begin
         mPos[i]  = 0;
         mAltN[i] = 0;
      end else if (!en) begin
         mPos[i] = 0;
      end else begin
         if (mPos[i] == 0) begin
            expFs[i] = 1'b1;
            mMode[i] = mode;
            case (mode)
               2'b01: mShadow[i] = frame_a;
               2'b10: mShadow[i] = frame_b;
               2'b11: mShadow[i] = (((mAltN[i] / pBlink[i]) % 2) == 1) ? frame_b : frame_a;
               default: mShadow[i] = '0;
            endcase
            if (mode == 2'b11) mAltN[i] = mAltN[i] + 1;
            else               mAltN[i] = 0;
         end else begin
            k   = mPos[i] - 1;
            col = k / (pBlank[i] + pDwell[i]);
            ph  = k % (pBlank[i] + pDwell[i]);
            expIdx[i] = col;
            if (ph >= pBlank[i] && mMode[i] != 2'b00) begin
               rawCols[col] = 1'b1;
               rawLines     = mShadow[i][col*NR +: NR];
            end
         end
         mPos[i] = (mPos[i] + 1) % period;
      end
      expCols[i]  = rawCols ^ {NC{pColLow[i]}};
      expLines[i] = rawLines ^ {NR{pRowLow[i]}};
   endtask

   // Drive one cycle of inputs, advance the model at the edge and compare
   // both instances on the following falling edge
   task automatic applyStimulus(input logic rstnV, input logic enV, input logic [1:0] modeV,
                                input logic [NC*NR-1:0] fa, input logic [NC*NR-1:0] fb);
      rst_n   = rstnV;
      en      = enV;
      mode    = modeV;
      frame_a = fa;
      frame_b = fb;
      @(posedge clk);
      modelEdge(0);
      modelEdge(1);
      cycle++;
      @(negedge clk);
      checkOutput("d0.columns",     32'(columns0),    32'(expCols[0]));
      checkOutput("d0.lines",       32'(lines0),      32'(expLines[0]));
      checkOutput("d0.col_idx",     32'(colIdx0),     32'(expIdx[0]));
      checkOutput("d0.frame_start", 32'(frameStart0), 32'(expFs[0]));
      checkOutput("d1.columns",     32'(columns1),    32'(expCols[1]));
      checkOutput("d1.lines",       32'(lines1),      32'(expLines[1]));
      checkOutput("d1.col_idx",     32'(colIdx1),     32'(expIdx[1]));
      checkOutput("d1.frame_start", 32'(frameStart1), 32'(expFs[1]));
   endtask

   // Stimulus sequence: reset, fixed pattern, alternate, off, then random
   // traffic with mid-frame source changes, enable drops and resets
   initial begin
      logic [NC*NR-1:0] fa, fb;
      logic [1:0]       m;
      logic [7:0]       pattern [NC];
      logic             r, e;
      pattern = '{8'h3C, 8'h12, 8'h5A, 8'h61, 8'h77};
      for (int i = 0; i < 2; i++) begin
         mPos[i] = 0; mShadow[i] = '0; mMode[i] = 2'b00; mAltN[i] = 0;
      end
      rst_n = 1'b0; en = 1'b1; mode = 2'b00; frame_a = '0; frame_b = '0;
      @(negedge clk);

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'b01, '0, '0);

      fa = '0;
      for (int c = 0; c < NC; c++) fa[c*NR +: NR] = pattern[c][NR-1:0];
      fb = randFrame();
      for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1, 2'b01, fa, fb);

      // Sources keep changing mid-frame; only START may pick them up
      for (int i = 0; i < 240; i++) begin
         if ($urandom_range(7) == 0) fa = randFrame();
         if ($urandom_range(7) == 0) fb = randFrame();
         applyStimulus(1'b1, 1'b1, 2'b11, fa, fb);
      end

      for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1, 2'b00, randFrame(), randFrame());

      m = 2'b10;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(29) == 0) m = 2'($urandom_range(3));
         if ($urandom_range(5) == 0)  fa = randFrame();
         if ($urandom_range(5) == 0)  fb = randFrame();
         e = ($urandom_range(39) != 0);
         r = ($urandom_range(99) != 0);
         applyStimulus(r, e, m, fa, fb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
